// File: rtl/snes_mem_pkg.sv
// Shared definitions for the SNES cart-ROM / SDRAM memory path.
//
// Contents:
//   MAX_TAG_W      - widest word tag any bridge instance may use (ADDR_W <= 32)
//   rom_tag_t      - word tag (byte address >> 1), zero-extended to MAX_TAG_W
//   bridge_state_t - ROM bridge FSM states
//   rom_entry_t    - one buffered ROM word {valid, tag, data}
//   next_tag()     - tag + 1, wrapped to the live tag width
package snes_mem_pkg;

    localparam int MAX_TAG_W = 31;

    typedef logic [MAX_TAG_W-1:0] rom_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DREQ  = 3'd1,
        ST_DWAIT = 3'd2,
        ST_PREQ  = 3'd3,
        ST_PWAIT = 3'd4
    } bridge_state_t;

    typedef struct packed {
        logic       valid;
        rom_tag_t   tag;
        logic [15:0] data;
    } rom_entry_t;

    // Sequential successor of a tag; the all-ones tag wraps to zero.
    function automatic rom_tag_t next_tag(input rom_tag_t tag, input int tag_w);
        rom_tag_t mask;
        mask = rom_tag_t'((64'd1 << tag_w) - 64'd1);
        return (tag + rom_tag_t'(1)) & mask;
    endfunction

endpackage

// File: rtl/rom_sdram_bridge_if.sv
// Bus bundle between the cart mapper, the ROM bridge and the SDRAM controller.
//
// Signals:
//   rom_addr, rom_ce_n, rom_oe_n, rom_word - ROM read bus from the mapper
//   rom_q, busy                            - ROM read data and stall back to the mapper
//   inval                                  - ROM reload: drop all buffered words
//   sdr_req, sdr_addr                      - SDRAM read request (word aligned)
//   sdr_ack, sdr_q                         - SDRAM completion pulse and data
// Modports:
//   slave  - the bridge
//   master - the environment (mapper + SDRAM controller)
interface rom_sdram_bridge_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ce_n;
    logic              rom_oe_n;
    logic              rom_word;
    logic [15:0]       rom_q;
    logic              inval;
    logic              busy;
    logic              sdr_req;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_ack;
    logic [15:0]       sdr_q;

    modport slave (
        input  rom_addr, rom_ce_n, rom_oe_n, rom_word, inval, sdr_ack, sdr_q,
        output rom_q, busy, sdr_req, sdr_addr
    );

    modport master (
        output rom_addr, rom_ce_n, rom_oe_n, rom_word, inval, sdr_ack, sdr_q,
        input  rom_q, busy, sdr_req, sdr_addr
    );
endinterface

// File: rtl/rom_buf_entry.sv
// One buffered ROM word: valid bit, word tag and 16-bit data, with a tag
// comparator for hit detection.
//
// Ports:
//   mclk, rst  - clock, asynchronous active-high reset
//   clear      - drop the valid bit (wins over load)
//   load       - replace the whole entry with load_val
//   load_val   - new entry contents
//   cmp_tag    - tag to compare against
//   entry      - current entry contents
//   hit        - entry is valid and its tag equals cmp_tag
module rom_buf_entry
    import snes_mem_pkg::*;
(
    input  logic       mclk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  rom_entry_t load_val,
    input  rom_tag_t   cmp_tag,
    output rom_entry_t entry,
    output logic       hit
);

    rom_entry_t entry_q;
    rom_entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (clear) begin
            entry_d.valid = 1'b0;
        end else if (load) begin
            entry_d = load_val;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;
    assign hit   = entry_q.valid && (entry_q.tag == cmp_tag);

endmodule

// File: rtl/rom_sdram_bridge.sv
// Cart ROM to SDRAM read bridge with a two-word buffer (demand + sequential
// prefetch). ROM reads that hit either buffered word are answered one cycle
// later without touching SDRAM; misses fetch the word, and while idle the
// bridge fetches the word after the demand word in the background.
//
// Ports:
//   mclk - sole clock
//   rst  - asynchronous active-high reset
//   bus  - rom_sdram_bridge_if.slave: ROM bus, inval, busy, SDRAM request/ack
// Parameters:
//   ADDR_W   - byte address width of ROM bus and SDRAM port (<= 32)
//   PREFETCH - 1 enables next-word prefetch
module rom_sdram_bridge
    import snes_mem_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter bit PREFETCH = 1'b1
)(
    input  logic                 mclk,
    input  logic                 rst,
    rom_sdram_bridge_if.slave    bus
);

    localparam int TAG_W = ADDR_W - 1;

    bridge_state_t     state_q, state_d;
    rom_tag_t          req_tag_q, req_tag_d;
    logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
    logic [15:0]       rom_q_q, rom_q_d;
    logic              busy_q, busy_d;
    logic              discard_q, discard_d;

    rom_entry_t dem_entry, pre_entry;
    logic       dem_hit, pre_hit;
    logic       dem_load, dem_clear, pre_load, pre_clear;
    rom_entry_t dem_load_val, fill_val;

    logic     active;
    rom_tag_t cur_tag;
    rom_tag_t nxt_tag;
    logic     use_dem, use_pre, ack_live, dem_fill, pre_fill, promote;
    logic     fill_match, pre_has_next;

    // The byte lane and access width do not change what is fetched.
    logic unused_rom_bits;
    assign unused_rom_bits = &{1'b0, bus.rom_word, bus.rom_addr[0]};

    assign cur_tag = rom_tag_t'(bus.rom_addr[ADDR_W-1:1]);

    rom_buf_entry u_demand (
        .mclk     (mclk),
        .rst      (rst),
        .clear    (dem_clear),
        .load     (dem_load),
        .load_val (dem_load_val),
        .cmp_tag  (cur_tag),
        .entry    (dem_entry),
        .hit      (dem_hit)
    );

    rom_buf_entry u_prefetch (
        .mclk     (mclk),
        .rst      (rst),
        .clear    (pre_clear),
        .load     (pre_load),
        .load_val (fill_val),
        .cmp_tag  (cur_tag),
        .entry    (pre_entry),
        .hit      (pre_hit)
    );

    // Hit detection and buffer maintenance. inval makes every buffered word
    // stale, so it also suppresses hits and any fill arriving with it. A
    // completing demand fill owns the DEMAND entry for that cycle; a prefetch
    // promotion that collides with it simply retries next cycle.
    always_comb begin
        active       = !bus.rom_ce_n && !bus.rom_oe_n;
        nxt_tag      = next_tag(dem_entry.tag, TAG_W);
        pre_has_next = pre_entry.valid && (pre_entry.tag == nxt_tag);
        use_dem      = active && !bus.inval && dem_hit;
        use_pre      = active && !bus.inval && pre_hit && !dem_hit;
        ack_live     = bus.sdr_ack && !discard_q && !bus.inval;
        dem_fill     = (state_q == ST_DWAIT) && ack_live;
        pre_fill     = (state_q == ST_PWAIT) && ack_live;
        promote      = use_pre && !dem_fill;
        fill_match   = dem_fill && (req_tag_q == cur_tag);

        fill_val     = '{valid: 1'b1, tag: req_tag_q, data: bus.sdr_q};
        dem_load     = dem_fill || promote;
        dem_load_val = dem_fill ? fill_val : pre_entry;
        dem_clear    = bus.inval;
        pre_load     = pre_fill;
        pre_clear    = bus.inval || (promote && !pre_fill);

        rom_q_d = rom_q_q;
        if (use_dem) begin
            rom_q_d = dem_entry.data;
        end else if (use_pre) begin
            rom_q_d = pre_entry.data;
        end
        if (fill_match) begin
            rom_q_d = bus.sdr_q;
        end

        busy_d = active && !(use_dem || use_pre || fill_match);
    end

    // Request sequencer. Only one SDRAM read is ever outstanding; a miss seen
    // while a read is in flight waits for it and is re-evaluated from IDLE.
    // discard marks an in-flight read whose data went stale via inval.
    always_comb begin
        state_d    = state_q;
        req_tag_d  = req_tag_q;
        sdr_addr_d = sdr_addr_q;
        discard_d  = discard_q;

        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (active && !use_dem && !use_pre) begin
                    state_d   = ST_DREQ;
                    req_tag_d = cur_tag;
                end else if (PREFETCH && !bus.inval && !promote &&
                             dem_entry.valid && !pre_has_next) begin
                    state_d   = ST_PREQ;
                    req_tag_d = nxt_tag;
                end
                if (state_d != ST_IDLE) begin
                    sdr_addr_d = {req_tag_d[TAG_W-1:0], 1'b0};
                end
            end
            ST_DREQ, ST_PREQ: begin
                state_d = (state_q == ST_DREQ) ? ST_DWAIT : ST_PWAIT;
                if (bus.inval) begin
                    discard_d = 1'b1;
                end
            end
            ST_DWAIT, ST_PWAIT: begin
                if (bus.sdr_ack) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end else if (bus.inval) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_tag_q  <= '0;
            sdr_addr_q <= '0;
            rom_q_q    <= '0;
            busy_q     <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_tag_q  <= req_tag_d;
            sdr_addr_q <= sdr_addr_d;
            rom_q_q    <= rom_q_d;
            busy_q     <= busy_d;
            discard_q  <= discard_d;
        end
    end

    assign bus.sdr_req  = (state_q == ST_DREQ) || (state_q == ST_PREQ);
    assign bus.sdr_addr = sdr_addr_q;
    assign bus.rom_q    = rom_q_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rom_sdram_bridge.sv
// Directed bench for rom_sdram_bridge. The stimulus process queues the SDRAM
// requests it expects (address + data the SDRAM answers with) and the rom_q
// values it expects to see, in order. An SDRAM model process checks each
// request against the queue and acks it three cycles later; a ROM monitor
// process checks every change of rom_q against the other queue.
module tb_rom_sdram_bridge;

    localparam int ADDR_W = 24;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } req_t;

    logic mclk;
    logic rst;

    rom_sdram_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    rom_sdram_bridge #(
        .ADDR_W   (ADDR_W),
        .PREFETCH (1'b1)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    req_t        exp_req[$];
    logic [15:0] exp_rom[$];
    int          checks   = 0;
    int          failures = 0;

    int          ack_cnt  = 0;
    logic [15:0] ack_data = 16'h0;
    req_t        cur_req;
    logic [15:0] last_rom = 16'h0;
    logic [15:0] exp_rom_val;

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] addr, input logic [15:0] data);
        req_t r;
        r.addr = addr;
        r.data = data;
        exp_req.push_back(r);
    endtask

    task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input logic ce_n,
                                  input logic oe_n);
        @(negedge mclk);
        bus.rom_addr = addr;
        bus.rom_ce_n = ce_n;
        bus.rom_oe_n = oe_n;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // SDRAM model: checks each request, answers three cycles later.
    initial begin
        bus.sdr_ack = 1'b0;
        bus.sdr_q   = 16'h0;
        forever begin
            @(negedge mclk);
            bus.sdr_ack = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    bus.sdr_ack = 1'b1;
                    bus.sdr_q   = ack_data;
                end
            end
            if (bus.sdr_req === 1'b1) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_sdr_req: got addr 0x%0h, expected no request",
                             bus.sdr_addr);
                    ack_data = 16'hDEAD;
                end else begin
                    cur_req = exp_req.pop_front();
                    check_output("sdr_addr", 32'(bus.sdr_addr), 32'(cur_req.addr));
                    ack_data = cur_req.data;
                end
                ack_cnt = 3;
            end
        end
    end

    // ROM monitor: every new rom_q value must be the next one expected.
    initial begin
        forever begin
            @(negedge mclk);
            if (bus.rom_q !== last_rom) begin
                if (exp_rom.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rom_q: got 0x%0h, expected no change from 0x%0h",
                             bus.rom_q, last_rom);
                end else begin
                    exp_rom_val = exp_rom.pop_front();
                    check_output("rom_q_update", 32'(bus.rom_q), 32'(exp_rom_val));
                end
                last_rom = bus.rom_q;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.rom_addr = '0;
        bus.rom_ce_n = 1'b1;
        bus.rom_oe_n = 1'b1;
        bus.rom_word = 1'b1;
        bus.inval    = 1'b0;
        #1;
        check_output("reset_rom_q",    32'(bus.rom_q),    32'h0);
        check_output("reset_busy",     32'(bus.busy),     32'h0);
        check_output("reset_sdr_req",  32'(bus.sdr_req),  32'h0);
        check_output("reset_sdr_addr", 32'(bus.sdr_addr), 32'h0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);

        // Cold read, followed by the background prefetch of the next word.
        push_req(24'h008000, 16'hA55A);
        push_req(24'h008002, 16'h1234);
        exp_rom.push_back(16'hA55A);
        apply_stimulus(24'h008000, 1'b0, 1'b0);
        @(negedge mclk);
        check_output("cold_busy_high", 32'(bus.busy), 32'h1);
        wait_cycles(14);
        check_output("cold_busy_low", 32'(bus.busy), 32'h0);
        check_output("cold_rom_q", 32'(bus.rom_q), 32'hA55A);

        // Odd byte of the same word: demand hit, nothing fetched.
        apply_stimulus(24'h008001, 1'b0, 1'b0);
        wait_cycles(4);
        check_output("byte_hit_rom_q", 32'(bus.rom_q), 32'hA55A);
        check_output("byte_hit_busy", 32'(bus.busy), 32'h0);

        // Next word hits the prefetch entry in one cycle; prefetch moves on.
        push_req(24'h008004, 16'h5678);
        exp_rom.push_back(16'h1234);
        apply_stimulus(24'h008003, 1'b0, 1'b0);
        @(negedge mclk);
        check_output("seq_hit_rom_q", 32'(bus.rom_q), 32'h1234);
        check_output("seq_hit_busy", 32'(bus.busy), 32'h0);
        wait_cycles(12);

        // inval while waiting: first answer dropped, same word refetched.
        push_req(24'h008010, 16'hBEEF);
        push_req(24'h008010, 16'hC0DE);
        push_req(24'h008012, 16'h2222);
        exp_rom.push_back(16'hC0DE);
        apply_stimulus(24'h008010, 1'b0, 1'b0);
        wait_cycles(2);
        bus.inval = 1'b1;
        @(negedge mclk);
        bus.inval = 1'b0;
        wait_cycles(3);
        check_output("inval_rom_q_kept", 32'(bus.rom_q), 32'h1234);
        check_output("inval_busy", 32'(bus.busy), 32'h1);
        wait_cycles(14);
        check_output("refetch_rom_q", 32'(bus.rom_q), 32'hC0DE);

        // Top-of-space word: prefetch wraps to address 0.
        push_req(24'hFFFFFE, 16'h7777);
        push_req(24'h000000, 16'h0001);
        exp_rom.push_back(16'h7777);
        apply_stimulus(24'hFFFFFE, 1'b0, 1'b0);
        wait_cycles(16);
        check_output("wrap_rom_q", 32'(bus.rom_q), 32'h7777);
        push_req(24'h000002, 16'h0002);
        exp_rom.push_back(16'h0001);
        apply_stimulus(24'h000001, 1'b0, 1'b0);
        @(negedge mclk);
        check_output("wrap_hit_rom_q", 32'(bus.rom_q), 32'h0001);
        wait_cycles(12);

        // Inactive accesses fetch nothing and never stall.
        apply_stimulus(24'h123456, 1'b1, 1'b0);
        wait_cycles(6);
        check_output("ce_off_busy", 32'(bus.busy), 32'h0);
        check_output("ce_off_rom_q", 32'(bus.rom_q), 32'h0001);
        apply_stimulus(24'h123456, 1'b0, 1'b1);
        wait_cycles(4);
        check_output("oe_off_busy", 32'(bus.busy), 32'h0);

        // Reset while waiting; the late ack must be ignored.
        push_req(24'h004000, 16'h9999);
        apply_stimulus(24'h004000, 1'b0, 1'b0);
        wait_cycles(2);
        exp_rom.push_back(16'h0000);
        rst          = 1'b1;
        bus.rom_ce_n = 1'b1;
        #1;
        check_output("rst_mid_sdr_req", 32'(bus.sdr_req), 32'h0);
        check_output("rst_mid_rom_q", 32'(bus.rom_q), 32'h0);
        check_output("rst_mid_busy", 32'(bus.busy), 32'h0);
        @(negedge mclk);
        rst = 1'b0;
        wait_cycles(6);
        check_output("stray_ack_rom_q", 32'(bus.rom_q), 32'h0);
        check_output("stray_ack_busy", 32'(bus.busy), 32'h0);
        check_output("stray_ack_sdr_req", 32'(bus.sdr_req), 32'h0);
        check_output("stray_ack_sdr_addr", 32'(bus.sdr_addr), 32'h0);

        // inval in the same cycle as the ack: data dropped, word refetched.
        push_req(24'h008000, 16'h1111);
        push_req(24'h008000, 16'hA55A);
        push_req(24'h008002, 16'h1234);
        exp_rom.push_back(16'hA55A);
        apply_stimulus(24'h008000, 1'b0, 1'b0);
        wait_cycles(4);
        bus.inval = 1'b1;
        @(negedge mclk);
        bus.inval = 1'b0;
        wait_cycles(16);
        check_output("inval_ack_rom_q", 32'(bus.rom_q), 32'hA55A);

        wait_cycles(4);
        check_output("req_queue_drained", 32'(exp_req.size()), 32'h0);
        check_output("rom_queue_drained", 32'(exp_rom.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
